// File: rtl/sync_pkg.sv
// Shared constants and UART FSM state encoding for the sync/UART line transmitter.
package sync_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_t;

   localparam int DEF_CLK_DIV     = 434;
   localparam int DEF_N_PERIOD    = 5000000;
   localparam int UART_DATA_BITS  = 8;
   localparam int UART_STOP_BITS  = 1;
   localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

   function automatic int frame_clks(input int n_bytes, input int clk_div);
      return n_bytes * UART_FRAME_BITS * clk_div;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte 8N1 serializer. done pulses during the last STOP cycle so the next byte
// can be accepted on the same edge, giving gap-free back-to-back bytes.
module uart_tx_byte
   import sync_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int CLK_DIV_CW = 9
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   uart_state_t           r_state;
   logic [CLK_DIV_CW-1:0] r_cnt;
   logic [2:0]            r_bit;
   logic [7:0]            r_shift;
   logic                  r_tx;
   logic                  r_done;
   logic                  w_bit_end;

   assign w_bit_end = (r_cnt == CLK_DIV_CW'(CLK_DIV - 1));
   assign tx        = r_tx;
   assign done      = r_done;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_cnt  <= w_bit_end ? '0 : r_cnt + CLK_DIV_CW'(1);
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (start) begin
                  r_state <= ST_START;
                  r_tx    <= 1'b0;
                  r_shift <= data;
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_state <= ST_DATA;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  if (r_bit == 3'(UART_DATA_BITS - 1)) begin
                     r_state <= ST_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end
            end
            ST_STOP: begin
               // Early by one so the caller sees done while STOP is still on the line
               r_done <= (r_cnt == CLK_DIV_CW'(CLK_DIV - 2));
               if (w_bit_end) begin
                  if (start) begin
                     r_state <= ST_START;
                     r_tx    <= 1'b0;
                     r_shift <= data;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sync_uart_tx.sv
// Periodic sync/UART frame generator: every N_PERIOD clocks sends the 32-bit sync index, LSB byte first.
// Define SYNC_TX_CKSUM_EN to append one XOR-of-payload checksum byte to every frame.
module sync_uart_tx
   import sync_pkg::*;
#(
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int CLK_DIV_CW  = 9,
   parameter int N_PERIOD    = DEF_N_PERIOD,
   parameter int N_PERIOD_CW = 23,
   parameter int N_BYTES     = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   output logic        sync_line,
   output logic        sync_pulse,
   output logic        busy,
   output logic [31:0] sync_idx
);

`ifdef SYNC_TX_CKSUM_EN
   localparam int N_FRAME = N_BYTES + 1;
`else
   localparam int N_FRAME = N_BYTES;
`endif
   localparam int FW     = 8 * N_FRAME;
   localparam int LEFT_W = $clog2(N_FRAME) + 1;

   logic [N_PERIOD_CW-1:0] r_period;
   logic [31:0]            r_sync_idx;
   logic [FW-1:0]          r_shift;
   logic [LEFT_W-1:0]      r_left;
   logic                   r_busy;
   logic                   r_pulse;
   logic [8*N_BYTES-1:0]   w_payload;
   logic [FW-1:0]          w_frame;
   logic [7:0]             w_data;
   logic                   w_launch;
   logic                   w_next;
   logic                   w_start;
   logic                   w_tx;
   logic                   w_done;

   // Payload bytes beyond the 32-bit index are sent as zero
   for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_payload
      if (gi < 4) begin : g_idx
         assign w_payload[8*gi +: 8] = r_sync_idx[8*gi +: 8];
      end else begin : g_pad
         assign w_payload[8*gi +: 8] = 8'h00;
      end
   end

`ifdef SYNC_TX_CKSUM_EN
   logic [7:0] w_cksum;
   always_comb begin
      w_cksum = 8'h00;
      for (int i = 0; i < N_BYTES; i++) begin
         w_cksum = w_cksum ^ w_payload[8*i +: 8];
      end
   end
   assign w_frame = {w_cksum, w_payload};
`else
   assign w_frame = w_payload;
`endif

   assign w_launch = en && (r_period == '0) && !r_busy;
   assign w_next   = w_done && (r_left != '0);
   assign w_start  = w_launch || w_next;
   assign w_data   = w_launch ? w_frame[7:0] : r_shift[7:0];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_period   <= '0;
         r_sync_idx <= '0;
         r_shift    <= '0;
         r_left     <= '0;
         r_busy     <= 1'b0;
         r_pulse    <= 1'b0;
      end else begin
         r_pulse <= w_launch;
         if (!en || r_period == N_PERIOD_CW'(N_PERIOD - 1)) begin
            r_period <= '0;
         end else begin
            r_period <= r_period + N_PERIOD_CW'(1);
         end
         if (w_launch) begin
            r_sync_idx <= r_sync_idx + 32'd1;
            r_shift    <= w_frame >> 8;
            r_left     <= LEFT_W'(N_FRAME - 1);
            r_busy     <= 1'b1;
         end else if (w_done) begin
            if (r_left != '0) begin
               r_shift <= r_shift >> 8;
               r_left  <= r_left - LEFT_W'(1);
            end else begin
               r_busy <= 1'b0;
            end
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rstn) begin
         assert (!(en && r_period == '0 && r_busy));
         assert (frame_clks(N_FRAME, CLK_DIV) < N_PERIOD);
      end
   end
`endif

   uart_tx_byte #(
      .CLK_DIV    (CLK_DIV),
      .CLK_DIV_CW (CLK_DIV_CW)
   ) u_tx_byte (
      .clk   (clk),
      .rstn  (rstn),
      .start (w_start),
      .data  (w_data),
      .tx    (w_tx),
      .done  (w_done)
   );

   assign sync_line  = w_tx;
   assign sync_pulse = r_pulse;
   assign busy       = r_busy;
   assign sync_idx   = r_sync_idx;

endmodule

// File: tb/tb_sync_uart_tx.sv
// Randomized self-checking bench for sync_uart_tx against a frame-level line model.
`timescale 1ns/1ps
module tb_sync_uart_tx;

   localparam int CLK_DIV    = 4;
   localparam int N_BYTES    = 4;
`ifdef SYNC_TX_CKSUM_EN
   localparam int NF         = N_BYTES + 1;
   localparam int N_PERIOD   = 250;
`else
   localparam int NF         = N_BYTES;
   localparam int N_PERIOD   = 200;
`endif
   localparam int BYTE_CLKS  = 10 * CLK_DIV;
   localparam int FRAME_CLKS = NF * BYTE_CLKS;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0;
   logic        sync_line;
   logic        sync_pulse;
   logic        busy;
   logic [31:0] sync_idx;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_idx;
   logic [8*NF-1:0] exp_v;
   logic [8*NF-1:0] cap_v;
   int          cap_wave_err, cap_busy, cap_pulse;
   logic        cap_busy_after;

   sync_uart_tx #(
      .CLK_DIV     (CLK_DIV),
      .CLK_DIV_CW  (3),
      .N_PERIOD    (N_PERIOD),
      .N_PERIOD_CW (8),
      .N_BYTES     (N_BYTES)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .sync_line  (sync_line),
      .sync_pulse (sync_pulse),
      .busy       (busy),
      .sync_idx   (sync_idx)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected frame bytes: index LSB first, optional XOR checksum last
   function automatic void model_frame(input logic [31:0] idx);
      exp_v        = '0;
      exp_v[31:0]  = idx;
`ifdef SYNC_TX_CKSUM_EN
      exp_v[8*N_BYTES +: 8] = idx[7:0] ^ idx[15:8] ^ idx[23:16] ^ idx[31:24];
`endif
   endfunction

   // Line level t clocks after the sync instant: start=0, 8 data bits, stop=1
   function automatic logic exp_line(input int t);
      int b, p;
      b = t / BYTE_CLKS;
      p = (t % BYTE_CLKS) / CLK_DIV;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return exp_v[b*8 + p - 1];
   endfunction

   // Record one frame starting at the pulse cycle; decode bytes at bit centres
   task automatic run_frame(input int drop_at);
      int p;
      cap_wave_err = 0;
      cap_busy     = 0;
      cap_pulse    = 0;
      cap_v        = '0;
      for (int t = 0; t < FRAME_CLKS; t++) begin
         if (t == drop_at) en = 1'b0;
         if (sync_line !== exp_line(t)) cap_wave_err++;
         if (busy === 1'b1) cap_busy++;
         if (sync_pulse === 1'b1) cap_pulse++;
         p = (t % BYTE_CLKS) / CLK_DIV;
         if ((t % CLK_DIV) == CLK_DIV / 2 && p >= 1 && p <= 8)
            cap_v[(t / BYTE_CLKS) * 8 + p - 1] = sync_line;
         step();
      end
      cap_busy_after = busy;
   endtask

   task automatic wait_pulse(input int max_cycles, output int waited);
      waited = 0;
      while (sync_pulse !== 1'b1 && waited < max_cycles) begin
         step();
         waited++;
      end
   endtask

   task automatic wait_idle(output bit ok);
      int n;
      n = 0;
      step();
      while (busy !== 1'b0 && n < 2 * FRAME_CLKS) begin
         step();
         n++;
      end
      ok = (busy === 1'b0);
   endtask

   task automatic test_reset();
      int bad_line, bad_pulse, bad_busy, bad_idx;
      bad_line = 0; bad_pulse = 0; bad_busy = 0; bad_idx = 0;
      rstn = 1'b0;
      en   = 1'b0;
      repeat (3) step();
      rstn = 1'b1;
      model_idx = 32'h0;
      for (int i = 0; i < 500; i++) begin
         if (sync_line !== 1'b1) bad_line++;
         if (sync_pulse !== 1'b0) bad_pulse++;
         if (busy !== 1'b0) bad_busy++;
         if (sync_idx !== 32'h0) bad_idx++;
         step();
      end
      checks++; if (bad_line != 0) begin errors++; $display("FAIL reset_line bad_cycles=%0d required 0", bad_line); end
      checks++; if (bad_pulse != 0) begin errors++; $display("FAIL reset_pulse bad_cycles=%0d required 0", bad_pulse); end
      checks++; if (bad_busy != 0) begin errors++; $display("FAIL reset_busy bad_cycles=%0d required 0", bad_busy); end
      checks++; if (bad_idx != 0) begin errors++; $display("FAIL reset_idx bad_cycles=%0d required 0", bad_idx); end
      $display("test_reset: 500 idle cycles observed");
   endtask

   task automatic test_periodic();
      int w;
      en = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            wait_pulse(N_PERIOD, w);
            checks++; if (FRAME_CLKS + w != N_PERIOD) begin errors++; $display("FAIL period_gap got %0d required %0d", FRAME_CLKS + w, N_PERIOD); end
         end
         model_frame(model_idx);
         model_idx = model_idx + 32'd1;
         checks++; if (sync_pulse !== 1'b1) begin errors++; $display("FAIL periodic_pulse frame %0d got %b required 1", k, sync_pulse); end
         checks++; if (sync_line !== 1'b0) begin errors++; $display("FAIL periodic_edge frame %0d got %b required 0", k, sync_line); end
         checks++; if (sync_idx !== model_idx) begin errors++; $display("FAIL periodic_idx got %h required %h", sync_idx, model_idx); end
         run_frame(-1);
         checks++; if (cap_v !== exp_v) begin errors++; $display("FAIL periodic_bytes got %h required %h", cap_v, exp_v); end
         checks++; if (cap_wave_err != 0) begin errors++; $display("FAIL periodic_bittime wrong_samples=%0d required 0", cap_wave_err); end
         checks++; if (cap_busy != FRAME_CLKS) begin errors++; $display("FAIL periodic_busy got %0d required %0d", cap_busy, FRAME_CLKS); end
         checks++; if (cap_pulse != 1) begin errors++; $display("FAIL periodic_pulses got %0d required 1", cap_pulse); end
         checks++; if (cap_busy_after !== 1'b0) begin errors++; $display("FAIL periodic_busy_end got %b required 0", cap_busy_after); end
         $display("test_periodic: frame %0d bytes %h", k, cap_v);
      end
   endtask

   task automatic test_index_load();
      logic [31:0] vals [3];
      bit ok;
      int w;
      vals[0] = 32'hFFFF_FFFF;
      vals[1] = 32'h1234_5678;
      vals[2] = $urandom;
      for (int v = 0; v < 3; v++) begin
         en = 1'b0;
         wait_idle(ok);
         checks++; if (!ok) begin errors++; $display("FAIL index_idle busy=%b required 0", busy); end
         force dut.r_sync_idx = vals[v];
         step();
         release dut.r_sync_idx;
         step();
         checks++; if (sync_idx !== vals[v]) begin errors++; $display("FAIL index_load got %h required %h", sync_idx, vals[v]); end
         model_idx = vals[v];
         en = 1'b1;
         step();
         for (int k = 0; k < 2; k++) begin
            if (k > 0) begin
               wait_pulse(N_PERIOD, w);
               checks++; if (FRAME_CLKS + w != N_PERIOD) begin errors++; $display("FAIL index_gap got %0d required %0d", FRAME_CLKS + w, N_PERIOD); end
            end
            model_frame(model_idx);
            model_idx = model_idx + 32'd1;
            checks++; if (sync_pulse !== 1'b1) begin errors++; $display("FAIL index_pulse got %b required 1", sync_pulse); end
            checks++; if (sync_idx !== model_idx) begin errors++; $display("FAIL index_next got %h required %h", sync_idx, model_idx); end
            run_frame(-1);
            checks++; if (cap_v !== exp_v) begin errors++; $display("FAIL index_bytes got %h required %h", cap_v, exp_v); end
            checks++; if (cap_wave_err != 0) begin errors++; $display("FAIL index_bittime wrong_samples=%0d required 0", cap_wave_err); end
            checks++; if (cap_busy != FRAME_CLKS) begin errors++; $display("FAIL index_busy got %0d required %0d", cap_busy, FRAME_CLKS); end
`ifdef SYNC_TX_CKSUM_EN
            if (k == 0 && vals[v] == 32'h1234_5678) begin
               checks++; if (cap_v[8*N_BYTES +: 8] !== 8'h08) begin errors++; $display("FAIL cksum_byte got %h required 08", cap_v[8*N_BYTES +: 8]); end
            end
`endif
            $display("test_index_load: start %h frame %0d bytes %h", vals[v], k, cap_v);
         end
      end
   endtask

   task automatic test_en_drop();
      bit ok;
      int drop, pulses;
      en = 1'b0;
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_idle busy=%b required 0", busy); end
      for (int it = 0; it < 2; it++) begin
         drop = (it == 0) ? 20 : int'($urandom_range(1, FRAME_CLKS - 1));
         en = 1'b1;
         step();
         model_frame(model_idx);
         model_idx = model_idx + 32'd1;
         checks++; if (sync_pulse !== 1'b1) begin errors++; $display("FAIL drop_relaunch got %b required 1", sync_pulse); end
         checks++; if (sync_line !== 1'b0) begin errors++; $display("FAIL drop_edge got %b required 0", sync_line); end
         run_frame(drop);
         checks++; if (cap_v !== exp_v) begin errors++; $display("FAIL drop_bytes got %h required %h", cap_v, exp_v); end
         checks++; if (cap_busy != FRAME_CLKS) begin errors++; $display("FAIL drop_busy got %0d required %0d", cap_busy, FRAME_CLKS); end
         pulses = 0;
         for (int i = 0; i < N_PERIOD + 20; i++) begin
            if (sync_pulse === 1'b1) pulses++;
            step();
         end
         checks++; if (pulses != 0) begin errors++; $display("FAIL drop_quiet pulses=%0d required 0", pulses); end
         $display("test_en_drop: en dropped at %0d, bytes %h", drop, cap_v);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int t_rst;
      en = 1'b0;
      wait_idle(ok);
      t_rst = $urandom_range(CLK_DIV, 9 * CLK_DIV - 1);
      en = 1'b1;
      step();
      repeat (t_rst) step();
      rstn = 1'b0;
      step();
      checks++; if (sync_line !== 1'b1) begin errors++; $display("FAIL rst_line got %b required 1", sync_line); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
      checks++; if (sync_idx !== 32'h0) begin errors++; $display("FAIL rst_idx got %h required 0", sync_idx); end
      rstn = 1'b1;
      en   = 1'b0;
      model_idx = 32'h0;
      step();
      en = 1'b1;
      step();
      model_frame(model_idx);
      model_idx = model_idx + 32'd1;
      checks++; if (sync_pulse !== 1'b1) begin errors++; $display("FAIL rst_relaunch got %b required 1", sync_pulse); end
      run_frame(-1);
      checks++; if (cap_v !== exp_v) begin errors++; $display("FAIL rst_bytes got %h required %h", cap_v, exp_v); end
      checks++; if (cap_wave_err != 0) begin errors++; $display("FAIL rst_bittime wrong_samples=%0d required 0", cap_wave_err); end
      $display("test_reset_mid: reset at t=%0d, next bytes %h", t_rst, cap_v);
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_index_load();
      test_en_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
